// File: rtl/comp_strg_pkg.sv
// Shared definitions for the computation-storage scheduler: command and
// state encodings plus the default bus widths.
package comp_strg_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    CMD_RD  = 2'b00,
    CMD_WR  = 2'b01,
    CMD_ADD = 2'b10,
    CMD_SUB = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/comp_strg_sched_if.sv
// Bundle of the two requester ports, the storage command bus and status.
// master = requester/storage environment, slave = scheduler.
interface comp_strg_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  p0_req_valid;
  logic                  p0_req_ready;
  logic [1:0]            p0_req_cmd;
  logic [ADDR_WIDTH-1:0] p0_req_addA;
  logic [ADDR_WIDTH-1:0] p0_req_addB;
  logic [ADDR_WIDTH-1:0] p0_req_addC;
  logic [DATA_WIDTH-1:0] p0_req_wdata;
  logic                  p0_rsp_valid;
  logic [DATA_WIDTH-1:0] p0_rsp_data;

  logic                  p1_req_valid;
  logic                  p1_req_ready;
  logic [1:0]            p1_req_cmd;
  logic [ADDR_WIDTH-1:0] p1_req_addA;
  logic [ADDR_WIDTH-1:0] p1_req_addB;
  logic [ADDR_WIDTH-1:0] p1_req_addC;
  logic [DATA_WIDTH-1:0] p1_req_wdata;
  logic                  p1_rsp_valid;
  logic [DATA_WIDTH-1:0] p1_rsp_data;

  logic                  s_en;
  logic [1:0]            s_cmd;
  logic [ADDR_WIDTH-1:0] s_addA;
  logic [ADDR_WIDTH-1:0] s_addB;
  logic [ADDR_WIDTH-1:0] s_addC;
  logic [DATA_WIDTH-1:0] s_dq_o;
  logic                  s_dq_oe;
  logic [DATA_WIDTH-1:0] s_dq_i;
  logic                  s_valid_out;

  logic                  busy;
  logic                  err;

  modport master (
    output p0_req_valid, p0_req_cmd, p0_req_addA, p0_req_addB, p0_req_addC, p0_req_wdata,
    input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
    output p1_req_valid, p1_req_cmd, p1_req_addA, p1_req_addB, p1_req_addC, p1_req_wdata,
    input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
    input  s_en, s_cmd, s_addA, s_addB, s_addC, s_dq_o, s_dq_oe,
    output s_dq_i, s_valid_out,
    input  busy, err
  );

  modport slave (
    input  p0_req_valid, p0_req_cmd, p0_req_addA, p0_req_addB, p0_req_addC, p0_req_wdata,
    output p0_req_ready, p0_rsp_valid, p0_rsp_data,
    input  p1_req_valid, p1_req_cmd, p1_req_addA, p1_req_addB, p1_req_addC, p1_req_wdata,
    output p1_req_ready, p1_rsp_valid, p1_rsp_data,
    output s_en, s_cmd, s_addA, s_addB, s_addC, s_dq_o, s_dq_oe,
    input  s_dq_i, s_valid_out,
    output busy, err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright; when both
// request, the one that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant; last_grant=1 hands priority to requester 0.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/comp_strg_sched.sv
// Round-robin scheduler in front of the computation storage block. Accepts
// one command at a time from p0/p1, presents it to the storage bus for a
// single ISSUE cycle and, for reads, returns DQ to the issuing requester.
module comp_strg_sched
  import comp_strg_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  comp_strg_sched_if.slave bus
);

  // Indexed views of the two request ports so the latch can mux by winner id
  logic [1:0]            req_valid;
  logic [1:0]            req_cmd   [2];
  logic [ADDR_WIDTH-1:0] req_addA  [2];
  logic [ADDR_WIDTH-1:0] req_addB  [2];
  logic [ADDR_WIDTH-1:0] req_addC  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  assign req_valid    = {bus.p1_req_valid, bus.p0_req_valid};
  assign req_cmd[0]   = bus.p0_req_cmd;
  assign req_cmd[1]   = bus.p1_req_cmd;
  assign req_addA[0]  = bus.p0_req_addA;
  assign req_addA[1]  = bus.p1_req_addA;
  assign req_addB[0]  = bus.p0_req_addB;
  assign req_addB[1]  = bus.p1_req_addB;
  assign req_addC[0]  = bus.p0_req_addC;
  assign req_addC[1]  = bus.p1_req_addC;
  assign req_wdata[0] = bus.p0_req_wdata;
  assign req_wdata[1] = bus.p1_req_wdata;

  state_e                state_reg;
  cmd_e                  cmd_reg;
  logic                  last_grant_reg;
  logic                  owner_reg;
  logic                  s_en_reg;
  logic [1:0]            s_cmd_reg;
  logic [ADDR_WIDTH-1:0] s_addA_reg;
  logic [ADDR_WIDTH-1:0] s_addB_reg;
  logic [ADDR_WIDTH-1:0] s_addC_reg;
  logic [DATA_WIDTH-1:0] s_dq_o_reg;
  logic                  s_dq_oe_reg;
  logic                  err_reg;

  logic [1:0]            grant;
  logic [1:0]            accept;
  logic                  win_id;
  logic                  win_is_wr;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Ready is only offered while idle, and only to the arbitration winner
  assign accept    = (state_reg == ST_IDLE) ? grant : 2'b00;
  assign win_id    = grant[1];
  assign win_is_wr = (req_cmd[win_id] == CMD_WR);

  assign bus.p0_req_ready = accept[0];
  assign bus.p1_req_ready = accept[1];

  // Command FSM: latch the winner straight into the storage-bus registers,
  // drop them after the single ISSUE cycle, then wait one cycle for read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cmd_reg        <= CMD_RD;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      s_en_reg       <= 1'b0;
      s_cmd_reg      <= 2'b00;
      s_addA_reg     <= '0;
      s_addB_reg     <= '0;
      s_addC_reg     <= '0;
      s_dq_o_reg     <= '0;
      s_dq_oe_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|accept) begin
            state_reg      <= ST_ISSUE;
            cmd_reg        <= cmd_e'(req_cmd[win_id]);
            owner_reg      <= win_id;
            last_grant_reg <= win_id;
            s_en_reg       <= 1'b1;
            s_cmd_reg      <= req_cmd[win_id];
            s_addA_reg     <= req_addA[win_id];
            s_addB_reg     <= req_addB[win_id];
            s_addC_reg     <= req_addC[win_id];
            s_dq_oe_reg    <= win_is_wr;
            s_dq_o_reg     <= win_is_wr ? req_wdata[win_id] : '0;
          end
        end
        ST_ISSUE: begin
          state_reg   <= (cmd_reg == CMD_RD) ? ST_RD_WAIT : ST_IDLE;
          s_en_reg    <= 1'b0;
          s_cmd_reg   <= 2'b00;
          s_addA_reg  <= '0;
          s_addB_reg  <= '0;
          s_addC_reg  <= '0;
          s_dq_oe_reg <= 1'b0;
          s_dq_o_reg  <= '0;
        end
        ST_RD_WAIT: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error: storage failed to flag read data, or both sides drove DQ
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (((state_reg == ST_RD_WAIT) && !bus.s_valid_out) ||
                 (s_dq_oe_reg && bus.s_valid_out)) begin
      err_reg <= 1'b1;
    end
  end

  // Per-requester response registers
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data [2];

  for (genvar gi = 0; gi < 2; gi++) begin : gen_rsp
    logic                  rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;

    // Capture DQ for the owning requester at the end of RD_WAIT; one-cycle valid
    always_ff @(posedge clk) begin
      if (rst) begin
        rsp_valid_reg <= 1'b0;
        rsp_data_reg  <= '0;
      end else begin
        rsp_valid_reg <= 1'b0;
        if ((state_reg == ST_RD_WAIT) && (owner_reg == 1'(gi))) begin
          rsp_valid_reg <= 1'b1;
          rsp_data_reg  <= bus.s_dq_i;
        end
      end
    end

    assign rsp_valid[gi] = rsp_valid_reg;
    assign rsp_data[gi]  = rsp_data_reg;
  end

  assign bus.p0_rsp_valid = rsp_valid[0];
  assign bus.p0_rsp_data  = rsp_data[0];
  assign bus.p1_rsp_valid = rsp_valid[1];
  assign bus.p1_rsp_data  = rsp_data[1];

  assign bus.s_en    = s_en_reg;
  assign bus.s_cmd   = s_cmd_reg;
  assign bus.s_addA  = s_addA_reg;
  assign bus.s_addB  = s_addB_reg;
  assign bus.s_addC  = s_addC_reg;
  assign bus.s_dq_o  = s_dq_o_reg;
  assign bus.s_dq_oe = s_dq_oe_reg;
  assign bus.busy    = (state_reg != ST_IDLE);
  assign bus.err     = err_reg;

endmodule

// File: tb/tb_comp_strg_sched.sv
// Bench for comp_strg_sched: a storage-block emulator on the bus, a
// timeline reference model (accept cycle -> issue/response cycles, memory
// updated in accept order) checked every cycle, plus directed literal checks.
module tb_comp_strg_sched;
  import comp_strg_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp_strg_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  comp_strg_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic [DW-1:0] wd;
  } req_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- storage block emulator ----------------
  logic [DW-1:0] st_mem [1024];
  logic [DW-1:0] st_dq = '0;
  logic          st_drive = 1'b0;
  logic          st_valid = 1'b0;
  bit            drop_valid = 1'b0;
  logic [DW-1:0] dq_bus;

  assign dq_bus          = bus.s_dq_oe ? bus.s_dq_o : (st_drive ? st_dq : '0);
  assign bus.s_dq_i      = dq_bus;
  assign bus.s_valid_out = st_valid;

  always @(posedge clk) begin
    st_drive <= 1'b0;
    st_valid <= 1'b0;
    if (bus.s_en) begin
      case (bus.s_cmd)
        2'b00: begin
          st_dq    <= st_mem[bus.s_addA];
          st_drive <= 1'b1;
          st_valid <= !drop_valid;
        end
        2'b01:   st_mem[bus.s_addC] <= dq_bus;
        2'b10:   st_mem[bus.s_addC] <= st_mem[bus.s_addA] + st_mem[bus.s_addB];
        default: st_mem[bus.s_addC] <= st_mem[bus.s_addA] - st_mem[bus.s_addB];
      endcase
    end
  end

  // ---------------- stimulus queues and driver ----------------
  req_t q0[$];
  req_t q1[$];
  req_t drv0 = '0;
  req_t drv1 = '0;
  bit   v0 = 1'b0;
  bit   v1 = 1'b0;
  bit   gap_en = 1'b0;
  bit   acc0 = 1'b0;
  bit   acc1 = 1'b0;

  task automatic apply_bus();
    bus.p0_req_valid = v0;  bus.p0_req_cmd = drv0.cmd;
    bus.p0_req_addA = drv0.a; bus.p0_req_addB = drv0.b; bus.p0_req_addC = drv0.c;
    bus.p0_req_wdata = drv0.wd;
    bus.p1_req_valid = v1;  bus.p1_req_cmd = drv1.cmd;
    bus.p1_req_addA = drv1.a; bus.p1_req_addB = drv1.b; bus.p1_req_addC = drv1.c;
    bus.p1_req_wdata = drv1.wd;
  endtask

  initial begin : driver
    apply_bus();
    forever begin
      @(posedge clk);
      #1;
      if (acc0) begin void'(q0.pop_front()); v0 = 1'b0; end
      if (acc1) begin void'(q1.pop_front()); v1 = 1'b0; end
      if (!v0 && q0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        v0 = 1'b1; drv0 = q0[0];
      end
      if (!v1 && q1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        v1 = 1'b1; drv1 = q1[0];
      end
      apply_bus();
    end
  end

  task automatic push(input int k, input logic [1:0] cmd, input int a, input int b,
                      input int c, input logic [31:0] wd);
    req_t r;
    r.cmd = cmd; r.a = AW'(a); r.b = AW'(b); r.c = AW'(c); r.wd = wd;
    if (k == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  // ---------------- reference model ----------------
  bit            model_on = 1'b0;
  int            free_at = 0;
  bit            m_last = 1'b1;
  int            iss_cyc = -1;
  int            rsp_cyc = -1;
  int            rsp_owner = 0;
  req_t          m_cur = '0;
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] m_pending = '0;
  logic [DW-1:0] m_rsp_data [2];
  bit            m_err = 1'b0;
  int            rd_acc_cyc [2];

  function automatic int pick(input bit a0, input bit a1, input bit last);
    if (a0 && a1) return last ? 0 : 1;
    if (a0) return 0;
    if (a1) return 1;
    return -1;
  endfunction

  int   mw;
  req_t mr;
  always @(posedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      model_on = 1'b1;
      free_at = cyc + 1;
      m_last = 1'b1;
      iss_cyc = -1;
      rsp_cyc = -1;
      m_rsp_data[0] = '0;
      m_rsp_data[1] = '0;
      m_err = 1'b0;
    end else if (model_on) begin
      if (cyc == rsp_cyc - 1) begin
        m_rsp_data[rsp_owner] = m_pending;
        if (drop_valid) m_err = 1'b1;
      end
      if (cyc >= free_at) begin
        mw = pick(v0, v1, m_last);
        if (mw >= 0) begin
          mr = (mw == 0) ? drv0 : drv1;
          if (mw == 0) acc0 = 1'b1; else acc1 = 1'b1;
          m_last = (mw == 1);
          m_cur = mr;
          iss_cyc = cyc + 1;
          free_at = cyc + 2;
          case (mr.cmd)
            2'b00: begin
              m_pending = ref_mem[mr.a];
              rsp_cyc = cyc + 3;
              rsp_owner = mw;
              free_at = cyc + 3;
              rd_acc_cyc[mw] = cyc;
            end
            2'b01:   ref_mem[mr.c] = mr.wd;
            2'b10:   ref_mem[mr.c] = ref_mem[mr.a] + ref_mem[mr.b];
            default: ref_mem[mr.c] = ref_mem[mr.a] - ref_mem[mr.b];
          endcase
          $display("txn accept cyc=%0d p%0d cmd=%0d A=%0d B=%0d C=%0d wd=%h",
                   cyc, mw, mr.cmd, mr.a, mr.b, mr.c, mr.wd);
        end
      end
    end
    cyc = cyc + 1;
  end

  // ---------------- per-cycle compare ----------------
  int rsp0_cnt = 0, rsp1_cnt = 0, rsp0_cyc = 0, en_cnt = 0;
  int obs_grants[$];
  int cw;
  bit c_idle, c_iss, c_wr;
  always @(negedge clk) begin
    if (model_on) begin
      c_idle = (cyc >= free_at);
      cw = pick(v0, v1, m_last);
      c_iss = (cyc == iss_cyc);
      c_wr = c_iss && (m_cur.cmd == 2'b01);
      chk("p0_req_ready", bus.p0_req_ready, 32'(c_idle && cw == 0));
      chk("p1_req_ready", bus.p1_req_ready, 32'(c_idle && cw == 1));
      chk("s_en", bus.s_en, 32'(c_iss));
      chk("s_cmd", bus.s_cmd, c_iss ? 32'(m_cur.cmd) : 32'd0);
      chk("s_addA", bus.s_addA, c_iss ? 32'(m_cur.a) : 32'd0);
      chk("s_addB", bus.s_addB, c_iss ? 32'(m_cur.b) : 32'd0);
      chk("s_addC", bus.s_addC, c_iss ? 32'(m_cur.c) : 32'd0);
      chk("s_dq_oe", bus.s_dq_oe, 32'(c_wr));
      chk("s_dq_o", bus.s_dq_o, c_wr ? m_cur.wd : 32'd0);
      chk("busy", bus.busy, 32'(!c_idle));
      chk("p0_rsp_valid", bus.p0_rsp_valid, 32'(cyc == rsp_cyc && rsp_owner == 0));
      chk("p1_rsp_valid", bus.p1_rsp_valid, 32'(cyc == rsp_cyc && rsp_owner == 1));
      chk("p0_rsp_data", bus.p0_rsp_data, m_rsp_data[0]);
      chk("p1_rsp_data", bus.p1_rsp_data, m_rsp_data[1]);
      chk("err", bus.err, 32'(m_err));
      if (bus.p0_req_ready) obs_grants.push_back(0);
      if (bus.p1_req_ready) obs_grants.push_back(1);
      if (bus.s_en) en_cnt++;
      if (bus.p0_rsp_valid) begin
        rsp0_cnt++; rsp0_cyc = cyc;
        $display("txn rsp cyc=%0d p0 data=%h", cyc, bus.p0_rsp_data);
      end
      if (bus.p1_rsp_valid) begin
        rsp1_cnt++;
        $display("txn rsp cyc=%0d p1 data=%h", cyc, bus.p1_rsp_data);
      end
    end
  end

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0 && !v0 && !v1 &&
          cyc >= free_at && cyc > rsp_cyc) done = 1'b1;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  // ---------------- directed and random sequences ----------------
  int r0, r1, e0, got;
  int exp_g [4] = '{0, 1, 0, 1};
  initial begin : main
    for (int i = 0; i < 1024; i++) begin
      st_mem[i] = '0;
      ref_mem[i] = '0;
    end
    rd_acc_cyc[0] = 0;
    rd_acc_cyc[1] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", bus.busy, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_s_en", bus.s_en, 0);
    chk("reset_p0_rsp_data", bus.p0_rsp_data, 0);

    // 1: write, write, add, read on p0
    r0 = rsp0_cnt; r1 = rsp1_cnt;
    push(0, 2'b01, 0, 0, 5, 32'h000000AA);
    push(0, 2'b01, 0, 0, 6, 32'h00000011);
    push(0, 2'b10, 5, 6, 7, 32'h0);
    push(0, 2'b00, 7, 0, 0, 32'h0);
    wait_done();
    chk("t1_model_mem7", ref_mem[7], 32'h000000BB);
    chk("t1_rsp_data", bus.p0_rsp_data, 32'h000000BB);
    chk("t1_rsp_count", 32'(rsp0_cnt - r0), 1);
    chk("t1_p1_quiet", 32'(rsp1_cnt - r1), 0);
    chk("t1_latency", 32'(rsp0_cyc - rd_acc_cyc[0]), 3);

    // 2: subtraction wrap on p1
    push(1, 2'b11, 6, 5, 8, 32'h0);
    push(1, 2'b00, 8, 0, 0, 32'h0);
    wait_done();
    chk("t2_rsp_data", bus.p1_rsp_data, 32'hFFFFFF67);

    // 3: both requesters hold valid, grants alternate
    obs_grants.delete();
    e0 = en_cnt;
    push(0, 2'b01, 0, 0, 10, 32'h10101010);
    push(1, 2'b01, 0, 0, 11, 32'h11111111);
    push(0, 2'b01, 0, 0, 12, 32'h12121212);
    push(1, 2'b01, 0, 0, 13, 32'h13131313);
    wait_done();
    chk("t3_grant_count", 32'(obs_grants.size()), 4);
    if (obs_grants.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t3_grant_order", 32'(obs_grants[i]), 32'(exp_g[i]));
    chk("t3_s_en_count", 32'(en_cnt - e0), 4);

    // 4: read on p0 then write on p1 back to back, then read back
    push(0, 2'b00, 5, 0, 0, 32'h0);
    push(1, 2'b01, 0, 0, 20, 32'h5A5A1234);
    wait_done();
    chk("t4_read5", bus.p0_rsp_data, 32'h000000AA);
    push(0, 2'b00, 20, 0, 0, 32'h0);
    wait_done();
    chk("t4_readback20", bus.p0_rsp_data, 32'h5A5A1234);
    chk("t4_err", bus.err, 0);

    // 5: reset during RD_WAIT
    push(0, 2'b00, 7, 0, 0, 32'h0);
    got = 0;
    for (int i = 0; i < 50 && got == 0; i++) begin
      @(posedge clk);
      #1;
      if (acc0) got = 1;
    end
    chk("t5_read_accepted", 32'(got), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    r0 = rsp0_cnt;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_s_en", bus.s_en, 0);
    chk("t5_rsp_valid", bus.p0_rsp_valid, 0);
    chk("t5_err", bus.err, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_rsp", 32'(rsp0_cnt - r0), 0);
    obs_grants.delete();
    push(0, 2'b01, 0, 0, 30, 32'h00000030);
    push(1, 2'b01, 0, 0, 31, 32'h00000031);
    wait_done();
    chk("t5_grants_after_rst", 32'(obs_grants.size()), 2);
    if (obs_grants.size() > 0) chk("t5_p0_first", 32'(obs_grants[0]), 0);
    obs_grants.delete();
    push(1, 2'b00, 31, 0, 0, 32'h0);
    wait_done();
    chk("t5_p1_granted", 32'(obs_grants.size()), 1);
    chk("t5_p1_data", bus.p1_rsp_data, 32'h00000031);

    // 6: storage fails to raise valid during RD_WAIT
    drop_valid = 1'b1;
    push(0, 2'b00, 7, 0, 0, 32'h0);
    wait_done();
    drop_valid = 1'b0;
    chk("t6_err_set", bus.err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_err_sticky", bus.err, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_err_cleared", bus.err, 0);

    // Random traffic from both requesters with idle gaps
    gap_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), $urandom);
    end
    wait_done();
    chk("rand_err", bus.err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comp_strg_sched.md
Name: comp_strg_sched

Overview:
- Two-requester round-robin scheduler in front of the computation storage block (`comp_strg`).
- Accepts read/write/add/sub commands from requesters p0 and p1 over a valid/ready handshake.
- Sequences each command onto the storage block's `en`/`cmd`/`addA`/`addB`/`addC`/`DQ` interface.
- Returns read data to the requester that issued the read; the tri-state `DQ` bus is resolved in the integration wrapper.

Parameters:
- DATA_WIDTH, 32, width of storage words and DQ.
- ADDR_WIDTH, 10, width of addA/addB/addC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pN_req_valid  in  1  requester N (N=0,1) command valid
- pN_req_ready  out  1  requester N command accepted this cycle
- pN_req_cmd  in  2  00 read, 01 write, 10 add, 11 sub
- pN_req_addA / pN_req_addB / pN_req_addC  in  ADDR_WIDTH each  operand/destination addresses
- pN_req_wdata  in  DATA_WIDTH  write data (cmd 01 only)
- pN_rsp_valid  out  1  one-cycle pulse, read data for requester N
- pN_rsp_data  out  DATA_WIDTH  read data, held until next response
- s_en, s_cmd[1:0], s_addA, s_addB, s_addC  out  storage command bus
- s_dq_o  out  DATA_WIDTH  write data toward DQ
- s_dq_oe  out  1  drive enable for DQ (wrapper: DQ = s_dq_oe ? s_dq_o : 'z)
- s_dq_i  in  DATA_WIDTH  DQ as seen on the bus
- s_valid_out  in  1  storage read-data valid
- busy  out  1  state != IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge):
  - State IDLE; last_grant=1, so p0 has priority first.
  - All outputs 0, including rsp_data, s_dq_o and err.
  - Latched command cleared.
  - A reset mid-command abandons that command with no rsp_valid.
- States: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - pN_req_ready is combinational: asserted only in IDLE, for the arbitration winner only, and only when that pN_req_valid=1.
  - Arbitration: single valid wins. Both valid: the requester not equal to last_grant wins.
  - On handshake (valid&ready at posedge): latch cmd/addrs/wdata and owner id, set last_grant=owner, go to ISSUE.
- ISSUE (exactly one cycle):
  - s_en=1; s_cmd and s_addA/B/C come from the latch.
  - s_dq_oe=1 and s_dq_o=wdata only when cmd=01; otherwise s_dq_oe=0 and s_dq_o=0.
  - Next state: RD_WAIT if cmd=00, else IDLE.
- RD_WAIT (exactly one cycle):
  - s_en=0, s_dq_oe=0.
  - s_valid_out must be 1; if it is 0, set err.
  - At the posedge: owner rsp_data <= s_dq_i, owner rsp_valid <= 1 for one cycle, next state IDLE.
- Outside ISSUE: s_en=0 and s_addA/B/C=0.
- Bus turnaround:
  - Storage drives DQ the cycle after a read ISSUE (RD_WAIT).
  - s_dq_oe is never 1 in RD_WAIT, and s_valid_out is low again by the next ISSUE, so no contention occurs.
  - err is also set if s_dq_oe and s_valid_out are ever both 1.
- Latency and throughput:
  - Accept to s_en: 1 cycle.
  - Read accept to rsp_valid: 3 cycles.
  - One command per 2 cycles (write/add/sub) or per 3 cycles (read).
- Arithmetic is performed by the storage block and wraps mod 2^DATA_WIDTH; the scheduler does no arithmetic.
- Ordering:
  - A command issued in ISSUE is committed at that edge, so a later read of the same address sees the new value; no hazard stall is needed.
  - Per-requester order is preserved; no reordering.

Decomposition:
- Shared package `comp_strg_pkg` holds:
  - Command encodings CMD_RD=2'b00, CMD_WR=2'b01, CMD_ADD=2'b10, CMD_SUB=2'b11.
  - State encodings.
  - Default widths.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter (inputs req[1:0], last_grant; output grant[1:0]).
- FSM, latch and response registers stay in `comp_strg_sched`.

Test Plan:
1. p0 write addC=5 0x000000AA, write addC=6 0x00000011, add A=5 B=6 C=7, read A=7 -> p0_rsp_valid pulses once, p0_rsp_data=0x000000BB, 3 cycles after read accept; p1_rsp_valid stays 0.
2. p1 sub A=6 B=5 C=8, read A=8 -> p1_rsp_data=0xFFFFFF67 (wrap-around).
3. p0 and p1 both hold valid with writes to addC=10..13 -> grants alternate p0,p1,p0,p1; each accepted command gives s_en=1 exactly once, 1 cycle after accept.
4. Back-to-back p0 read A=5 then p1 write C=20 -> s_dq_oe and s_valid_out never both 1; err=0; readback of 20 returns the written value.
5. rst asserted during RD_WAIT of a read -> next cycle busy=0, s_en=0, no rsp_valid, err=0; a fresh p1 request after reset is granted with p0 priority restored.
6. Force s_valid_out=0 during RD_WAIT -> err=1 and remains 1 until rst.
